// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - load/store bridge to data memory and memory-mapped IO
module mem_io_bridge #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SW_W       = 16,
  parameter int unsigned KEY_W      = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [SW_W-1:0]   switch_in,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  input  logic              btn_in,
  output logic [DATA_W-1:0] led_out,
  output logic [DATA_W-1:0] seg_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_RD_LAT - 1);

  // IO word offsets within the 1 KB window
  localparam logic [7:0] OFF_SW  = 8'h00;
  localparam logic [7:0] OFF_KEY = 8'h01;
  localparam logic [7:0] OFF_BTN = 8'h02;
  localparam logic [7:0] OFF_LED = 8'h04;
  localparam logic [7:0] OFF_SEG = 8'h05;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              rd_valid_q;
  logic [31:0]       rd_data_q;
  logic              clr_key_q;
  logic              clr_btn_q;
  logic [KEY_W-1:0]  key_reg_q, key_reg_d;
  logic              key_new_q, key_new_d;
  logic              btn_s1_q, btn_s2_q, btn_s3_q;
  logic              btn_flag_q, btn_flag_d;
  logic [31:0]       led_q;
  logic [31:0]       seg_q;

  logic        is_io;
  logic        misal;
  logic [1:0]  a;
  logic [7:0]  off;
  logic        st_en;
  logic        io_wr;
  logic [31:0] sw_word;
  logic [31:0] key_word;
  logic [31:0] io_word;
  logic [31:0] lane_mem;
  logic [31:0] lane_io;
  logic        btn_rise;
  logic        clr_key;
  logic        clr_btn;

  // Pick the addressed lane, then sign- or zero-extend it to a full word
  function automatic logic [31:0] extend_lane(input logic [31:0] w, input logic [1:0] la,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (la)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = la[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    extend_lane = {{24{b[7] & ~uns}}, b};
      2'd1:    extend_lane = {{16{h[15] & ~uns}}, h};
      default: extend_lane = w;
    endcase
  endfunction

  assign a     = req_addr[1:0];
  assign off   = req_addr[9:2];
  assign is_io = (req_addr[31:10] == IO_BASE[31:10]);
  assign misal = ((req_size == 2'd1) && a[0]) || (req_size[1] && (a != 2'd0));
  assign st_en = req_wr && !req_rd && !misal;
  assign io_wr = st_en && is_io;

  assign mem_addr = {req_addr[31:2], 2'b00};
  assign stall    = rst_n && req_rd && (state_q != S_RESP);
  assign err      = rst_n && ((req_rd && (state_q == S_IDLE) && (misal || req_wr)) ||
                              (req_wr && !req_rd && misal));

  // Byte enables and lane-replicated write data for memory stores
  always_comb begin
    mem_we    = 4'b0000;
    mem_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        mem_wdata = {4{req_wdata[7:0]}};
        mem_we    = 4'b0001 << a;
      end
      2'd1: begin
        mem_wdata = {2{req_wdata[15:0]}};
        mem_we    = 4'b0011 << {a[1], 1'b0};
      end
      default: mem_we = 4'b1111;
    endcase
    if (!st_en || is_io) mem_we = 4'b0000;
  end

  // Readable IO registers, zero-padded to a word
  always_comb begin
    sw_word               = '0;
    sw_word[SW_W-1:0]     = switch_in;
    key_word              = '0;
    key_word[KEY_W-1:0]   = key_reg_q;
    key_word[KEY_W]       = key_new_q;
    case (off)
      OFF_SW:  io_word = sw_word;
      OFF_KEY: io_word = key_word;
      OFF_BTN: io_word = {30'b0, btn_s2_q, btn_flag_q};
      default: io_word = 32'h0;
    endcase
  end

  assign lane_mem = misal ? 32'h0 : extend_lane(mem_rdata, a, req_size, req_unsigned);
  assign lane_io  = misal ? 32'h0 : extend_lane(io_word, a, req_size, 1'b1);

  // Sticky flags: a new arrival in the clearing cycle wins over the clear
  assign clr_key  = (state_q == S_RESP) && clr_key_q;
  assign clr_btn  = (state_q == S_RESP) && clr_btn_q;
  assign btn_rise = btn_s2_q && !btn_s3_q;

  // Next state of the key and button flags
  always_comb begin
    key_reg_d  = key_reg_q;
    key_new_d  = key_new_q;
    btn_flag_d = btn_flag_q;
    if (clr_key) key_new_d = 1'b0;
    if (key_valid) begin
      key_new_d = 1'b1;
      key_reg_d = key_in;
    end
    if (clr_btn) btn_flag_d = 1'b0;
    if (btn_rise) btn_flag_d = 1'b1;
  end

  // Load FSM: counted wait states for memory, one-cycle response for IO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      clr_key_q  <= 1'b0;
      clr_btn_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_valid_q <= 1'b0;
          if (req_rd) begin
            clr_key_q <= is_io && !misal && (off == OFF_KEY);
            clr_btn_q <= is_io && !misal && (off == OFF_BTN);
            if (is_io) begin
              rd_data_q  <= lane_io;
              rd_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            rd_data_q  <= lane_mem;
            rd_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          rd_valid_q <= 1'b0;
          clr_key_q  <= 1'b0;
          clr_btn_q  <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Key latch, button synchroniser with edge detect, and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg_q  <= '0;
      key_new_q  <= 1'b0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_s3_q   <= 1'b0;
      btn_flag_q <= 1'b0;
    end else begin
      key_reg_q  <= key_reg_d;
      key_new_q  <= key_new_d;
      btn_s1_q   <= btn_in;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      btn_flag_q <= btn_flag_d;
    end
  end

  // LED and segment registers take the full store word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 32'h0;
      seg_q <= 32'h0;
    end else if (io_wr) begin
      if (off == OFF_LED) led_q <= req_wdata;
      if (off == OFF_SEG) seg_q <= req_wdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign led_out  = led_q;
  assign seg_out  = seg_q;

endmodule
